btn_event_queue: RTL and testbench

- Downstream consumer of the per-button debounce/one-shot stages.
- Turns up to NUM_BTNS one-shot pulses into an ordered queue of button-index events.
- The OTTER CPU drains the queue over a simple MMIO read-pop interface.
- Queued events raise an interrupt pulse on the OTTER INTR line.

---
 rtl/btn_event_queue_if.sv | 24 ++
 rtl/btn_event_queue.sv | 136 +++++++++++++
 tb/tb_btn_event_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_event_queue_if.sv
// MMIO-side bundle of btn_event_queue: pop/clear strobes from the OTTER, queue status back.
// EVT_TSTAMP exists only when BTN_EVT_TSTAMP_EN is defined.
interface btn_event_queue_if;
  logic        EVT_RD;
  logic        OVF_CLR;
  logic [7:0]  EVT_DATA;
  logic        EVT_VALID;
  logic [4:0]  EVT_COUNT;
  logic        INTR;
  logic        OVERFLOW;
`ifdef BTN_EVT_TSTAMP_EN
  logic [15:0] EVT_TSTAMP;

  modport master (output EVT_RD, OVF_CLR,
                  input  EVT_DATA, EVT_VALID, EVT_COUNT, INTR, OVERFLOW, EVT_TSTAMP);
  modport slave  (input  EVT_RD, OVF_CLR,
                  output EVT_DATA, EVT_VALID, EVT_COUNT, INTR, OVERFLOW, EVT_TSTAMP);
`else
  modport master (output EVT_RD, OVF_CLR,
                  input  EVT_DATA, EVT_VALID, EVT_COUNT, INTR, OVERFLOW);
  modport slave  (input  EVT_RD, OVF_CLR,
                  output EVT_DATA, EVT_VALID, EVT_COUNT, INTR, OVERFLOW);
`endif
endinterface

// File: rtl/btn_event_queue.sv
// Queues one-shot button presses as index events for the OTTER, with INTR pulse and sticky OVERFLOW.
// Optional BTN_EVT_TSTAMP_EN: each event carries the cycle-counter value it takes on the push edge.
module btn_event_queue #(
  parameter int unsigned NUM_BTNS   = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INTR_CLKS  = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_BTNS-1:0] DB_BTN,
  btn_event_queue_if.slave    bus
);
  localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [7:0]  LAST_C  = 8'(INTR_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state;
  logic [7:0]          icnt;
  logic                intr;
  logic                overflow;
  logic [NUM_BTNS-1:0] prev;
  logic [NUM_BTNS-1:0] pending;
  logic [NUM_BTNS-1:0] btn_rise;
  logic [NUM_BTNS-1:0] low_bit;
  logic [NUM_BTNS-1:0] clr_mask;
  logic [3:0]          push_idx;
  logic                push;
  logic                pop;
  logic                valid;
  logic                ovf_set;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [4:0]          count;
  logic [3:0]          mem [FIFO_DEPTH];

  assign btn_rise = DB_BTN & ~prev;
  assign valid    = (count != '0);
  assign pop      = bus.EVT_RD && valid;
  // Two's-complement trick isolates the lowest pending channel as a one-hot mask.
  assign low_bit  = pending & (~pending + 1'b1);
  assign push     = (pending != '0) && ((count < DEPTH_C) || pop);
  assign clr_mask = push ? low_bit : '0;
  assign ovf_set  = |(btn_rise & pending & ~clr_mask);

  always_comb begin
    push_idx = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (low_bit[i]) push_idx = push_idx | 4'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_idx;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      prev     <= '0;
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= ST_IDLE;
      icnt     <= '0;
      intr     <= 1'b0;
    end else begin
      prev    <= DB_BTN;
      pending <= (pending & ~clr_mask) | btn_rise;

      if (ovf_set)          overflow <= 1'b1;
      else if (bus.OVF_CLR) overflow <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        ST_IDLE: begin
          intr <= 1'b0;
          if (valid) begin
            state <= ST_PULSE;
            icnt  <= '0;
            intr  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (icnt == LAST_C) begin
            state <= ST_WAIT;
            intr  <= 1'b0;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        ST_WAIT: begin
          intr <= 1'b0;
          if (!valid && (pending == '0)) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.EVT_VALID = valid;
  assign bus.EVT_COUNT = count;
  assign bus.EVT_DATA  = valid ? {4'b0000, mem[rd_ptr]} : '0;
  assign bus.INTR      = intr;
  assign bus.OVERFLOW  = overflow;

`ifdef BTN_EVT_TSTAMP_EN
  logic [15:0] ts;
  logic [15:0] mem_ts [FIFO_DEPTH];

  always_ff @(posedge CLK) begin
    if (!RST_N) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  // Store ts+1 so the stamp equals the counter value right after the push edge.
  always_ff @(posedge CLK) begin
    if (push) mem_ts[wr_ptr] <= ts + 1'b1;
  end

  assign bus.EVT_TSTAMP = valid ? mem_ts[rd_ptr] : '0;
`endif
endmodule

// File: tb/tb_btn_event_queue.sv
// Directed self-checking bench for btn_event_queue (default parameters 5/4/3).
module tb_btn_event_queue;
  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] btn;
  int         nchk  = 0;
  int         nfail = 0;
  int         hi;

  btn_event_queue_if bus();

  btn_event_queue #(.NUM_BTNS(5), .FIFO_DEPTH(4), .INTR_CLKS(3)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .DB_BTN (btn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N       = 1'b0;
    btn         = '0;
    bus.EVT_RD  = 1'b0;
    bus.OVF_CLR = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.EVT_VALID), 32'd0);
    check("rst_count", 32'(bus.EVT_COUNT), 32'd0);
    check("rst_data",  32'(bus.EVT_DATA),  32'd0);
    check("rst_intr",  32'(bus.INTR),      32'd0);
    check("rst_ovf",   32'(bus.OVERFLOW),  32'd0);
`ifdef BTN_EVT_TSTAMP_EN
    check("rst_tstamp", 32'(bus.EVT_TSTAMP), 32'd0);
`endif

    // press btn2 on the 10th edge after reset release, hold 3 cycles
    RST_N = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    btn = 5'b00100;
    tick();
    check("lat_valid0", 32'(bus.EVT_VALID), 32'd0);
    tick();
    check("b2_valid", 32'(bus.EVT_VALID), 32'd1);
    check("b2_data",  32'(bus.EVT_DATA),  32'h02);
    check("b2_count", 32'(bus.EVT_COUNT), 32'd1);
    check("b2_intr0", 32'(bus.INTR),      32'd0);
`ifdef BTN_EVT_TSTAMP_EN
    check("b2_tstamp", 32'(bus.EVT_TSTAMP), 32'd11);
`endif
    tick();
    check("b2_intr1", 32'(bus.INTR), 32'd1);
    btn = '0;
    hi  = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      hi += int'(bus.INTR);
    end
    check("b2_intr_len", 32'(hi), 32'd3);
    check("b2_one_evt",  32'(bus.EVT_COUNT), 32'd1);

    // new press while in wait state: no second pulse
    btn = 5'b10000;
    tick();
    btn = '0;
    tick();
    check("wait_count", 32'(bus.EVT_COUNT), 32'd2);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hi += int'(bus.INTR);
    end
    check("wait_no_intr", 32'(hi), 32'd0);
    bus.EVT_RD = 1'b1;
    tick();
    check("drain1_data",  32'(bus.EVT_DATA),  32'h04);
    check("drain1_count", 32'(bus.EVT_COUNT), 32'd1);
    tick();
    check("drain2_valid", 32'(bus.EVT_VALID), 32'd0);
    check("drain2_data",  32'(bus.EVT_DATA),  32'h00);
    bus.EVT_RD = 1'b0;
    tick();

    // after draining, next press pulses INTR again
    btn = 5'b00010;
    tick();
    btn = '0;
    tick();
    check("re_intr0", 32'(bus.INTR), 32'd0);
    tick();
    check("re_intr1", 32'(bus.INTR), 32'd1);
    hi = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      hi += int'(bus.INTR);
    end
    check("re_intr_len", 32'(hi), 32'd3);
    bus.EVT_RD = 1'b1;
    tick();
    check("pop_last", 32'(bus.EVT_COUNT), 32'd0);
    tick();
    check("rd_empty_count", 32'(bus.EVT_COUNT), 32'd0);
    check("rd_empty_valid", 32'(bus.EVT_VALID), 32'd0);
    bus.EVT_RD = 1'b0;

    // btn0 and btn3 together: lowest index first
    btn = 5'b01001;
    tick();
    btn = '0;
    tick();
    tick();
    check("dual_count", 32'(bus.EVT_COUNT), 32'd2);
    check("dual_head",  32'(bus.EVT_DATA),  32'h00);
    bus.EVT_RD = 1'b1;
    tick();
    check("dual_pop1_data",  32'(bus.EVT_DATA),  32'h03);
    check("dual_pop1_count", 32'(bus.EVT_COUNT), 32'd1);
    tick();
    check("dual_pop2_count", 32'(bus.EVT_COUNT), 32'd0);
    bus.EVT_RD = 1'b0;

    // five presses into depth 4: btn4 stays pending
    btn = 5'b11111;
    tick();
    btn = '0;
    for (int i = 0; i < 5; i++) tick();
    check("full_count", 32'(bus.EVT_COUNT), 32'd4);
    check("full_head",  32'(bus.EVT_DATA),  32'h00);
    check("full_ovf0",  32'(bus.OVERFLOW),  32'd0);
    btn = 5'b10000;
    tick();
    btn = '0;
    check("ovf_set", 32'(bus.OVERFLOW), 32'd1);
    tick();
    check("ovf_count", 32'(bus.EVT_COUNT), 32'd4);
    bus.EVT_RD = 1'b1;
    tick();
    bus.EVT_RD = 1'b0;
    check("pp_count", 32'(bus.EVT_COUNT), 32'd4);
    check("pp_head",  32'(bus.EVT_DATA),  32'h01);

    // full with pending[1]: pop+push keeps count, tail gets 1
    btn = 5'b00010;
    tick();
    btn = '0;
    tick();
    check("p1_count",  32'(bus.EVT_COUNT), 32'd4);
    check("ovf_sticky", 32'(bus.OVERFLOW), 32'd1);
    bus.EVT_RD = 1'b1;
    tick();
    check("p1_pp_count", 32'(bus.EVT_COUNT), 32'd4);
    check("p1_pp_head",  32'(bus.EVT_DATA),  32'h02);
    tick();
    check("p1_d3", 32'(bus.EVT_DATA), 32'h03);
    tick();
    check("p1_d4", 32'(bus.EVT_DATA), 32'h04);
    tick();
    check("p1_tail", 32'(bus.EVT_DATA),  32'h01);
    check("p1_c1",   32'(bus.EVT_COUNT), 32'd1);
    tick();
    check("p1_c0", 32'(bus.EVT_COUNT), 32'd0);
    tick();
    check("p1_underflow", 32'(bus.EVT_COUNT), 32'd0);
    bus.EVT_RD = 1'b0;

    // btn1 re-rises in the cycle its pending bit is pushed: set wins
    btn = 5'b00011;
    tick();
    btn = '0;
    tick();
    btn = 5'b00010;
    tick();
    btn = '0;
    tick();
    check("setwin_count", 32'(bus.EVT_COUNT), 32'd3);
    check("setwin_intr",  32'(bus.INTR),      32'd1);

    // reset mid-pulse with 3 queued and OVERFLOW set
    RST_N = 1'b0;
    tick();
    check("mrst_intr",  32'(bus.INTR),      32'd0);
    check("mrst_count", 32'(bus.EVT_COUNT), 32'd0);
    check("mrst_ovf",   32'(bus.OVERFLOW),  32'd0);
    check("mrst_valid", 32'(bus.EVT_VALID), 32'd0);
    RST_N = 1'b1;
    tick();
    check("mrst_hold", 32'(bus.EVT_COUNT), 32'd0);

    // OVF_CLR, and overflow set beats simultaneous clear
    btn = 5'b11111;
    tick();
    btn = '0;
    for (int i = 0; i < 5; i++) tick();
    btn = 5'b10000;
    tick();
    check("ovf2_set", 32'(bus.OVERFLOW), 32'd1);
    btn = '0;
    bus.OVF_CLR = 1'b1;
    tick();
    check("ovf_clr", 32'(bus.OVERFLOW), 32'd0);
    btn = 5'b10000;
    tick();
    check("ovf_setwins", 32'(bus.OVERFLOW), 32'd1);
    btn = '0;
    bus.OVF_CLR = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
